spi_serializer_v2: RTL and testbench
====================================

Name: spi_serializer_v2

Overview:
Parametrised successor to the fixed 24-bit address serializer: a full-duplex SPI master shift engine with run-time bit count, clock divider and SPI mode (CPOL/CPHA). It accepts a parallel word over a valid/ready handshake, frames it with n_cs, and shifts it out on mosi. It simultaneously captures miso into a parallel result, which it returns with a one-cycle valid pulse. It sits between the control FSM and the external SPI flash/peripheral pins.

Parameters:
DATAW, 32, maximum transfer width in bits (shift register width)
CNTW, 6, width of nbits field; must satisfy 2^CNTW > DATAW
DIVW, 8, width of clk_div field
LSB_FIRST, 0, 0 = MSB of the active field shifted first; 1 = bit 0 first

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
valid_in  in  1  request valid
ready_out  out  1  engine idle, request accepted when valid_in && ready_out
data_in  in  DATAW  transmit word, right-aligned (bits nbits-1..0 used)
nbits  in  CNTW  transfer length, legal 1..DATAW
cpol  in  1  SPI clock idle level
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
clk_div  in  DIVW  half-period H = clk_div+1 clk cycles
n_cs  out  1  chip select, active low
spi_clk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in
data_out  out  DATAW  received word, right-aligned, upper bits zero
valid_out  out  1  one-cycle pulse, data_out valid
err  out  1  one-cycle pulse, illegal request rejected

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, n_cs=1, spi_clk=0, mosi=0, data_out=0, valid_out=0, err=0, ready_out=0. ready_out rises the first cycle after rst_n=1. Reset mid-transfer aborts immediately: n_cs=1 on the next edge, no valid_out.
- All outputs registered.
- IDLE: ready_out=1, n_cs=1, spi_clk follows cpol input (registered), mosi=0.
- Accept (valid_in && ready_out):
  - nbits==0 or nbits>DATAW: err=1 next cycle, stay IDLE, ready_out stays 1, no n_cs activity.
  - Otherwise latch data_in, nbits, cpol, cpha, clk_div; go SETUP; ready_out=0 next cycle. Inputs are ignored until IDLE is re-entered.
- SETUP: n_cs=0, spi_clk=cpol, lasts H cycles. mosi presents the first bit from SETUP entry (both modes; for cpha=1 the leading edge re-drives the same bit).
- SHIFT: 2*nbits half-periods of H cycles each. spi_clk toggles at each half-period boundary, giving nbits leading and nbits trailing edges.
  - cpha=0: sample miso on leading edges; advance mosi on trailing edges, except the last.
  - cpha=1: advance mosi on leading edges; sample miso on trailing edges.
  - spi_clk returns to cpol after the final edge.
- Sampled bits fill data_out in transmit order:
  - LSB_FIRST=0: first received bit lands in bit nbits-1.
  - LSB_FIRST=1: first received bit lands in bit 0.
- HOLD: n_cs=0, spi_clk=cpol, H cycles.
- DONE (1 cycle): n_cs=1, valid_out=1, data_out updated; then IDLE. data_out holds until the next completed transfer.
- Latency: n_cs low for exactly (2*nbits+2)*H cycles; valid_out fires the cycle n_cs returns high; ready_out=1 the following cycle. n_cs is high for at least 2 cycles between back-to-back transfers.
- Bit/divider counters saturate-free: nbits=DATAW and clk_div=2^DIVW-1 are legal and must not wrap early.

Test Plan:
1. Mode 0, clk_div=0, nbits=8, data_in=0xA5, miso looped from mosi -> mosi 1,0,1,0,0,1,0,1 on spi_clk rising edges; n_cs low 18 cycles; valid_out one pulse; data_out=0x000000A5.
2. Mode 3, clk_div=3, nbits=24, data_in=0x123456, miso driven 0xC3C3C3 MSB-first -> spi_clk idles 1, half-period 4 cycles, n_cs low 200 cycles, data_out=0x00C3C3C3.
3. nbits=0, then nbits=33 -> err pulses once each, n_cs stays 1, ready_out stays 1, valid_out never asserts.
4. Mode 1 transfer of 16 bits, rst_n=0 after 5 bits -> next edge n_cs=1, spi_clk=0, no valid_out. After release, a new 8-bit mode 0 transfer completes correctly.
5. valid_in held high with two queued words (0x11, 0x22, nbits=8) -> two transfers; n_cs high ≥2 cycles between; data_out=0x11 then 0x22 with looped miso.
6. LSB_FIRST=1 instance, nbits=32, data_in=0x80000001, looped miso -> mosi first bit 1 then thirty 0s then 1; data_out=0x80000001; nbits=32 accepted without err.

Source files
------------

// File: rtl/spi_serializer_v2.sv
// Full-duplex SPI master shift engine: run-time bit count, clock divider and
// CPOL/CPHA mode. Frames one request with n_cs and returns the captured word.
module spi_serializer_v2 #(
  parameter int DATAW     = 32,
  parameter int CNTW      = 6,
  parameter int DIVW      = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [DATAW-1:0] data_in,
  input  logic [CNTW-1:0]  nbits,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIVW-1:0]  clk_div,
  output logic             n_cs,
  output logic             spi_clk,
  output logic             mosi,
  input  logic             miso,
  output logic [DATAW-1:0] data_out,
  output logic             valid_out,
  output logic             err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIVW-1:0]  div_q, div_d, hdiv_q, hdiv_d;
  logic [CNTW:0]    half_q, half_d, h_nx, last_idx;
  logic [CNTW-1:0]  nb_q, nb_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DATAW-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d, tx_ld;
  logic             ncs_q, ncs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic             vld_q, vld_d, err_q, err_d, rdy_q, rdy_d;
  logic             edge_go;

  // MSB-first transfers left-justify the active field so the shifter always
  // exits from a fixed end regardless of nbits.
  function automatic logic [DATAW-1:0] align_tx(input logic [DATAW-1:0] d,
                                                input logic [CNTW-1:0]  n);
    if (LSB_FIRST != 0) return d;
    return d << (DATAW - int'(n));
  endfunction

  function automatic logic out_bit(input logic [DATAW-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATAW-1];
  endfunction

  function automatic logic [DATAW-1:0] tx_shift(input logic [DATAW-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATAW-1:0] rx_shift(input logic [DATAW-1:0] v,
                                                input logic             b);
    return (LSB_FIRST != 0) ? {b, v[DATAW-1:1]} : {v[DATAW-2:0], b};
  endfunction

  function automatic logic [DATAW-1:0] rx_align(input logic [DATAW-1:0] v,
                                                input logic [CNTW-1:0]  n);
    if (LSB_FIRST != 0) return v >> (DATAW - int'(n));
    return v;
  endfunction

  assign tx_ld    = align_tx(data_in, nbits);
  assign last_idx = {nb_q, 1'b0} - (CNTW+1)'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hdiv_d  = hdiv_q;
    half_d  = half_q;
    nb_d    = nb_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    edge_go = 1'b0;
    h_nx    = '0;

    case (state_q)
      S_IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = cpol;
        mosi_d = 1'b0;
        if (valid_in && rdy_q) begin
          if (nbits == '0 || int'(nbits) > DATAW) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            nb_d    = nbits;
            cpol_d  = cpol;
            cpha_d  = cpha;
            hdiv_d  = clk_div;
            div_d   = '0;
            tx_d    = tx_ld;
            rx_d    = '0;
            ncs_d   = 1'b0;
            mosi_d  = out_bit(tx_ld);
          end
        end
      end
      S_SETUP, S_SHIFT: begin
        if (div_q == hdiv_q) begin
          div_d = '0;
          if (state_q == S_SETUP) begin
            state_d = S_SHIFT;
            edge_go = 1'b1;
          end else if (half_q == last_idx) begin
            state_d = S_HOLD;
          end else begin
            edge_go = 1'b1;
            h_nx    = half_q + (CNTW+1)'(1);
          end
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      S_HOLD: begin
        if (div_q == hdiv_q) begin
          div_d   = '0;
          state_d = S_DONE;
          ncs_d   = 1'b1;
          mosi_d  = 1'b0;
          vld_d   = 1'b1;
          dout_d  = rx_align(rx_q, nb_q);
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Even half-periods open with a leading edge, odd ones with a trailing edge.
    if (edge_go) begin
      half_d = h_nx;
      sclk_d = ~sclk_q;
      if (cpha_q ? h_nx[0] : !h_nx[0]) rx_d = rx_shift(rx_q, miso);
      if (cpha_q ? (!h_nx[0] && h_nx != '0) : (h_nx[0] && h_nx != last_idx)) begin
        tx_d   = tx_shift(tx_q);
        mosi_d = out_bit(tx_d);
      end
    end

    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  // Working registers are (re)initialised on every accepted request.
  always_ff @(posedge clk) begin
    div_q  <= div_d;
    hdiv_q <= hdiv_d;
    half_q <= half_d;
    nb_q   <= nb_d;
    cpol_q <= cpol_d;
    cpha_q <= cpha_d;
    tx_q   <= tx_d;
    rx_q   <= rx_d;
  end

  assign ready_out = rdy_q;
  assign n_cs      = ncs_q;
  assign spi_clk   = sclk_q;
  assign mosi      = mosi_q;
  assign data_out  = dout_q;
  assign valid_out = vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_serializer_v2.sv
// Randomised bench for spi_serializer_v2: a waveform-level model predicts every
// output cycle for an MSB-first and an LSB-first instance sharing one stimulus.
module tb_spi_serializer_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [5:0]  nbits = '0;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic [7:0]  clk_div = '0;
  logic        loop = 1'b1;
  logic [31:0] pat = '0;
  logic        miso0, miso1;

  logic        ready0, ncs0, sclk0, mosi0, vld0, err0;
  logic        ready1, ncs1, sclk1, mosi1, vld1, err1;
  logic [31:0] dout0, dout1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_serializer_v2 #(.LSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready0),
    .data_in(data_in), .nbits(nbits), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .n_cs(ncs0), .spi_clk(sclk0), .mosi(mosi0), .miso(miso0),
    .data_out(dout0), .valid_out(vld0), .err(err0));

  spi_serializer_v2 #(.LSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready1),
    .data_in(data_in), .nbits(nbits), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .n_cs(ncs1), .spi_clk(sclk1), .mosi(mosi1), .miso(miso1),
    .data_out(dout1), .valid_out(vld1), .err(err1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // j-th bit in transmit order of an n-bit right-aligned word
  function automatic logic tbit(input logic [31:0] d, input int n, input int j, input bit lsb);
    if (j < 0 || j >= n) return 1'b0;
    return lsb ? d[j] : d[n-1-j];
  endfunction

  // Slave: presents bit 0 at n_cs fall, then steps on its shift edges.
  int s_edges = 0, s_idx = 0;
  logic s_prev = 1'b0;
  always @(negedge clk) begin
    if (ncs0) begin
      s_edges = 0;
      s_idx   = 0;
    end else if (sclk0 != s_prev) begin
      s_edges++;
      s_idx = cpha ? (s_edges - 1) / 2 : s_edges / 2;
      if (s_idx > int'(nbits) - 1) s_idx = int'(nbits) - 1;
    end
    s_prev = sclk0;
  end
  always_comb begin
    miso0 = loop ? mosi0 : tbit(pat, int'(nbits), s_idx, 1'b0);
    miso1 = loop ? mosi1 : tbit(pat, int'(nbits), s_idx, 1'b1);
  end

  typedef struct packed {
    logic        ncs;
    logic        sclk;
    logic [1:0]  mosi;
    logic        vld;
    logic [31:0] d0;
    logic [31:0] d1;
  } item_t;

  item_t q[$];
  item_t it;
  logic  e_ncs, e_sclk, e_vld, e_err, e_ready, m_ok = 1'b0;
  logic [1:0]  e_mosi;
  logic [31:0] e_d0, e_d1;
  logic [63:0] m_mask;
  int m_n, m_h, m_hp, m_j;

  // Model: a legal request expands into its full per-cycle output waveform.
  always @(posedge clk) begin
    e_err = 1'b0;
    if (!rst_n) begin
      q.delete();
      e_ncs = 1'b1; e_sclk = 1'b0; e_mosi = 2'b00; e_vld = 1'b0;
      e_d0 = '0; e_d1 = '0; e_ready = 1'b0; m_ok = 1'b1;
    end else if (q.size() == 0 && valid_in && e_ready && (nbits == 0 || nbits > 32)) begin
      e_err = 1'b1;
      e_ncs = 1'b1; e_sclk = cpol; e_mosi = 2'b00; e_vld = 1'b0; e_ready = 1'b1;
    end else begin
      if (q.size() == 0 && valid_in && e_ready) begin
        m_n = int'(nbits);
        m_h = int'(clk_div) + 1;
        m_mask = (64'd1 << m_n) - 64'd1;
        for (int t = 0; t < (2 * m_n + 2) * m_h; t++) begin
          m_hp = t / m_h;
          it = '0;
          it.sclk = (m_hp >= 1 && m_hp <= 2 * m_n) ? (cpol ^ (m_hp % 2 == 1)) : cpol;
          if (m_hp == 0) m_j = 0;
          else if (m_hp == 2 * m_n + 1) m_j = m_n - 1;
          else m_j = cpha ? (m_hp - 1) / 2 : m_hp / 2;
          if (m_j > m_n - 1) m_j = m_n - 1;
          it.mosi = {tbit(data_in, m_n, m_j, 1'b1), tbit(data_in, m_n, m_j, 1'b0)};
          q.push_back(it);
        end
        it = '0;
        it.ncs  = 1'b1;
        it.sclk = cpol;
        it.vld  = 1'b1;
        it.d0   = (loop ? data_in : pat) & m_mask[31:0];
        it.d1   = it.d0;
        q.push_back(it);
      end
      if (q.size() != 0) begin
        it = q.pop_front();
        e_ncs = it.ncs; e_sclk = it.sclk; e_mosi = it.mosi; e_vld = it.vld;
        if (it.vld) begin
          e_d0 = it.d0;
          e_d1 = it.d1;
        end
        e_ready = 1'b0;
      end else begin
        e_ncs = 1'b1; e_sclk = cpol; e_mosi = 2'b00; e_vld = 1'b0; e_ready = 1'b1;
      end
    end
  end

  int low_len = 0, last_low = 0, high_len = 0, last_high = 0;
  int vld_cnt = 0, err_cnt = 0;
  logic [31:0] last_vd = '0, prev_vd = '0;
  logic [63:0] cap0 = '0, cap1 = '0;
  logic p_sc0 = 1'b0, p_sc1 = 1'b0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ready0", ready0, e_ready);   chk("ready1", ready1, e_ready);
      chk("n_cs0", ncs0, e_ncs);        chk("n_cs1", ncs1, e_ncs);
      chk("spi_clk0", sclk0, e_sclk);   chk("spi_clk1", sclk1, e_sclk);
      chk("mosi0", mosi0, e_mosi[0]);   chk("mosi1", mosi1, e_mosi[1]);
      chk("valid_out0", vld0, e_vld);   chk("valid_out1", vld1, e_vld);
      chk("err0", err0, e_err);         chk("err1", err1, e_err);
      chk("data_out0", dout0, e_d0);    chk("data_out1", dout1, e_d1);
    end
    if (!ncs0) low_len++;
    else if (low_len > 0) begin last_low = low_len; low_len = 0; end
    if (ncs0) high_len++;
    else if (high_len > 0) begin last_high = high_len; high_len = 0; end
    if (vld0) begin vld_cnt++; prev_vd = last_vd; last_vd = dout0; end
    if (err0) err_cnt++;
    if (sclk0 && !p_sc0) cap0 = {cap0[62:0], mosi0};
    if (sclk1 && !p_sc1) cap1 = {cap1[62:0], mosi1};
    p_sc0 = sclk0;
    p_sc1 = sclk1;
  end

  task automatic send(input logic [31:0] d, input int n, input logic cp, input logic ch,
                      input int dv, input logic lp, input logic [31:0] p);
    int k;
    @(negedge clk);
    data_in = d; nbits = n[5:0]; cpol = cp; cpha = ch; clk_div = dv[7:0];
    loop = lp; pat = p; valid_in = 1'b1;
    k = 0;
    while (!ready0 && k < 200) begin @(negedge clk); k++; end
    chk("accept_in_time", (k < 200), 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_done();
    int c0, k;
    c0 = vld_cnt;
    k = 0;
    while (vld_cnt == c0 && k < 20000) begin @(negedge clk); k++; end
    chk("done_in_time", (k < 20000), 1);
    repeat (2) @(negedge clk);
  endtask

  int v0, e0, rn, rcp, rch, rdv, rlp;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_n_cs", ncs0, 1);
    chk("rst_ready", ready0, 0);
    chk("rst_spi_clk", sclk0, 0);
    chk("rst_data_out", dout0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ready0, 1);

    // Mode 0, H=1, 0xA5 looped
    v0 = vld_cnt;
    send(32'hA5, 8, 0, 0, 0, 1, 0);
    wait_done();
    chk("t1_mosi_rising", cap0[7:0], 8'hA5);
    chk("t1_ncs_low", last_low, 18);
    chk("t1_vld_pulses", vld_cnt - v0, 1);
    chk("t1_data_out", dout0, 32'h000000A5);

    // Mode 3, H=4, 24 bits, slave drives 0xC3C3C3
    send(32'h123456, 24, 1, 1, 3, 0, 32'hC3C3C3);
    wait_done();
    chk("t2_ncs_low", last_low, 200);
    chk("t2_data_out", dout0, 32'h00C3C3C3);
    chk("t2_idle_clk", sclk0, 1);

    // Illegal lengths
    v0 = vld_cnt; e0 = err_cnt;
    send(32'hFFFF, 0, 0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("t3_err_n0", err_cnt - e0, 1);
    send(32'hFFFF, 33, 0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("t3_err_n33", err_cnt - e0, 2);
    chk("t3_no_valid", vld_cnt - v0, 0);
    chk("t3_ready", ready0, 1);

    // Mode 1 16-bit transfer aborted by reset after 5 bits
    v0 = vld_cnt;
    send(32'hBEEF, 16, 0, 1, 1, 1, 0);
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_abort_ncs", ncs0, 1);
    chk("t4_abort_clk", sclk0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_no_valid", vld_cnt - v0, 0);
    send(32'h3C, 8, 0, 0, 0, 1, 0);
    wait_done();
    chk("t4_after_data", dout0, 32'h3C);

    // Back-to-back with valid held high
    v0 = vld_cnt;
    @(negedge clk);
    data_in = 32'h11; nbits = 6'd8; cpol = 0; cpha = 0; clk_div = 0; loop = 1; valid_in = 1'b1;
    while (!ready0) @(negedge clk);
    @(posedge clk);
    #1 data_in = 32'h22;
    @(negedge clk);
    for (int k = 0; k < 200 && !ready0; k++) @(negedge clk);
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_done();
    chk("t5_two_valids", vld_cnt - v0, 2);
    chk("t5_gap_ge2", (last_high >= 2), 1);
    chk("t5_first", prev_vd, 32'h11);
    chk("t5_second", last_vd, 32'h22);

    // Full width on the LSB-first instance
    e0 = err_cnt;
    send(32'h80000001, 32, 0, 0, 0, 1, 0);
    wait_done();
    chk("t6_mosi_order", cap1[31:0], 32'h80000001);
    chk("t6_data_out", dout1, 32'h80000001);
    chk("t6_no_err", err_cnt - e0, 0);

    // Largest divider with full width
    send(32'hDEADBEEF, 32, 1, 0, 255, 0, 32'h5A5AA5A5);
    wait_done();
    chk("maxdiv_ncs_low", last_low, 66 * 256);
    chk("maxdiv_data_out", dout0, 32'h5A5AA5A5);

    for (int r = 0; r < 30; r++) begin
      rn = $urandom_range(1, 32);
      if ($urandom_range(0, 9) == 0) rn = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(33, 63);
      rcp = $urandom_range(0, 1);
      rch = $urandom_range(0, 1);
      rdv = $urandom_range(0, 4);
      rlp = $urandom_range(0, 1);
      send($urandom, rn, rcp[0], rch[0], rdv, rlp[0], $urandom);
      if (rn == 0 || rn > 32) repeat (3) @(negedge clk);
      else wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
